prra_arbiter_ctrl: RTL

Sequential round-robin arbiter controller built around the pseudo-round-robin priority search used in the HyNoC router. It shares one resource, such as a router output port, between WIDTH requesters. It registers a one-hot grant that stays locked to the winner until the winner signals release or an optional hold timeout expires. It keeps the rotating priority state, so the last owner always gets the lowest priority in the next arbitration.

---
 rtl/prra_arbiter_ctrl_if.sv | 40 ++++
 rtl/prra_arbiter_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/prra_arbiter_ctrl_if.sv
// Arbiter handshake bundle: requesters drive request/owner_release, the
// arbiter drives the registered grant outputs.
//
// Handshake: request[i] is level-sensitive and sampled only at the rising
// edge of clk. owner_release is a single-cycle strobe from the current owner
// and is ignored while grant_valid=0. grant/grant_index/grant_valid change
// only at rising edges; grant is one-hot while grant_valid=1, all zeros
// otherwise. timeout is a one-cycle pulse marking a forced revocation.
// "release" is a reserved word, so the owner's strobe is named owner_release.
interface prra_arbiter_ctrl_if #(
  parameter int WIDTH      = 4,
  parameter int LOG2_WIDTH = $clog2(WIDTH)
);
  logic [WIDTH-1:0]      request;
  logic                  owner_release;
  logic [WIDTH-1:0]      grant;
  logic [LOG2_WIDTH-1:0] grant_index;
  logic                  grant_valid;
  logic                  timeout;

  // Requester side.
  modport master (
    output request,
    output owner_release,
    input  grant,
    input  grant_index,
    input  grant_valid,
    input  timeout
  );

  // Arbiter side.
  modport slave (
    input  request,
    input  owner_release,
    output grant,
    output grant_index,
    output grant_valid,
    output timeout
  );
endinterface

// File: rtl/prra_arbiter_ctrl.sv
// Sequential pseudo-round-robin arbiter. A winner is locked until it releases
// or the optional hold timeout fires; the last owner always gets the lowest
// priority in the following search. dbg_state exposes the FSM (0=IDLE,
// 1=LOCKED).
module prra_arbiter_ctrl #(
  parameter int WIDTH      = 4,
  parameter int LOG2_WIDTH = $clog2(WIDTH),
  parameter int MAX_HOLD   = 0,
  parameter int HOLD_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  prra_arbiter_ctrl_if.slave     bus,
  output logic                   dbg_state
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  // Counter value on which a hold expires; unused when MAX_HOLD is 0.
  localparam bit                  HOLD_EN     = (MAX_HOLD != 0);
  localparam int                  HOLD_LAST_I = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(HOLD_LAST_I);
  localparam logic [LOG2_WIDTH-1:0] LAST_RST  = LOG2_WIDTH'(WIDTH - 1);

  state_t                  state_q, state_n;
  logic [WIDTH-1:0]        grant_q, grant_n;
  logic [LOG2_WIDTH-1:0]   idx_q, idx_n;
  logic [LOG2_WIDTH-1:0]   last_q, last_n;
  logic [HOLD_WIDTH-1:0]   cnt_q, cnt_n;
  logic                    timeout_q, timeout_n;

  logic [LOG2_WIDTH-1:0]   search_base;
  logic [LOG2_WIDTH-1:0]   win_idx;
  logic                    win_found;
  logic [WIDTH-1:0]        win_onehot;
  logic                    hold_expired;
  logic                    end_event;

  // Priority search. While LOCKED the search only matters on an end event,
  // where the new "last" is the current owner, so the base is grant_index.
  // Offsets are scanned from farthest to nearest so the nearest set bit wins.
  always_comb begin
    int                    pos;
    logic [LOG2_WIDTH-1:0] pos_idx;
    pos         = 0;
    pos_idx     = '0;
    search_base = (state_q == S_LOCKED) ? idx_q : last_q;
    win_found   = 1'b0;
    win_idx     = '0;
    for (int k = WIDTH; k >= 1; k--) begin
      pos     = (int'(search_base) + k) % WIDTH;
      pos_idx = LOG2_WIDTH'(pos);
      if (bus.request[pos_idx]) begin
        win_found = 1'b1;
        win_idx   = pos_idx;
      end
    end
    win_onehot = {{(WIDTH-1){1'b0}}, 1'b1} << win_idx;
  end

  // End-of-hold detection: owner release or counter reaching its limit.
  always_comb begin
    hold_expired = HOLD_EN && (cnt_q == HOLD_LAST);
    end_event    = (state_q == S_LOCKED) && (bus.owner_release || hold_expired);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n   = state_q;
    grant_n   = grant_q;
    idx_n     = idx_q;
    last_n    = last_q;
    cnt_n     = cnt_q;
    timeout_n = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_n = win_onehot;
          idx_n   = win_idx;
          cnt_n   = '0;
          state_n = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (end_event) begin
          last_n    = idx_q;
          // A coinciding release makes this a normal handoff, not a timeout.
          timeout_n = hold_expired && !bus.owner_release;
          if (win_found) begin
            grant_n = win_onehot;
            idx_n   = win_idx;
            cnt_n   = '0;
          end else begin
            grant_n = '0;
            idx_n   = '0;
            state_n = S_IDLE;
          end
        end else if (cnt_q != {HOLD_WIDTH{1'b1}}) begin
          cnt_n = cnt_q + HOLD_WIDTH'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
        grant_n = '0;
        idx_n   = '0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      last_q    <= LAST_RST;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      grant_q   <= grant_n;
      idx_q     <= idx_n;
      last_q    <= last_n;
      cnt_q     <= cnt_n;
      timeout_q <= timeout_n;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_index = idx_q;
  assign bus.grant_valid = (state_q == S_LOCKED);
  assign bus.timeout     = timeout_q;
  assign dbg_state       = state_q;

endmodule
